job_control: RTL and testbench

Job-interface sequencer for the AFU. Sits directly downstream of the PSL job interface and upstream of the AFU work engine. Decodes START/RESET job commands, latches the WED, and pulses the engine start. It drives the engine reset sequence, reports running/done/error back to the PSL, and registers `done` through a fixed delay line to meet PSL timing.

---
 rtl/job_control.sv | 164 ++++++++++++++++
 tb/tb_job_control.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/job_control.sv
// job_control: PSL job-interface sequencer for the AFU.
// Decodes START/RESET, drives engine start/reset, reports done/error.
module job_control #(
  parameter int RESET_CYCLES = 4,
  parameter int DONE_DELAY   = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        job_valid,
  input  logic [7:0]  job_command,
  input  logic [63:0] job_address,
  output logic        job_running,
  output logic        job_done,
  output logic [63:0] job_error,
  output logic        job_cack,
  output logic        job_yield,
  output logic [63:0] wed,
  output logic        engine_start,
  output logic        engine_reset,
  input  logic        engine_done,
  input  logic        engine_error,
  input  logic [63:0] engine_error_code,
  input  logic        engine_idle
);

  localparam int CW =
    (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(RESET_CYCLES - 1);

  localparam logic [7:0] CMD_START = 8'h90;
  localparam logic [7:0] CMD_RESET = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    RESETTING
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [63:0]           wed_q, wed_d;
  logic [63:0]           err_q, err_d;
  logic                  run_q, run_d;
  logic                  start_q, start_d;
  logic                  ereset_q, ereset_d;
  logic [DONE_DELAY-1:0] done_q;
  logic                  done_req;
  logic                  cmd_start;
  logic                  cmd_reset;

  // Decode the single-cycle job command strobe.
  always_comb begin
    cmd_start = 1'b0;
    cmd_reset = 1'b0;
    if (job_valid) begin
      unique case (1'b1)
        (job_command == CMD_START): cmd_start = 1'b1;
        (job_command == CMD_RESET): cmd_reset = 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state logic; RESET outranks completion everywhere.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wed_d    = wed_q;
    err_d    = err_q;
    run_d    = run_q;
    start_d  = 1'b0;
    done_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_start) begin
          wed_d   = job_address;
          start_d = 1'b1;
          run_d   = 1'b1;
          state_d = RUNNING;
        end else if (cmd_reset) begin
          cnt_d   = CNT_LOAD;
          run_d   = 1'b0;
          state_d = RESETTING;
        end
      end
      RUNNING: begin
        if (cmd_reset) begin
          cnt_d   = CNT_LOAD;
          run_d   = 1'b0;
          state_d = RESETTING;
        end else if (engine_done) begin
          run_d    = 1'b0;
          err_d    = engine_error ? engine_error_code
                                  : 64'd0;
          done_req = 1'b1;
          state_d  = IDLE;
        end
      end
      RESETTING: begin
        run_d = 1'b0;
        if (cmd_reset) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          if (engine_idle) begin
            wed_d    = 64'd0;
            err_d    = 64'd0;
            done_req = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ereset_d = (state_d == RESETTING);
  end

  // Registered state and outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wed_q    <= 64'd0;
      err_q    <= 64'd0;
      run_q    <= 1'b0;
      start_q  <= 1'b0;
      ereset_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wed_q    <= wed_d;
      err_q    <= err_d;
      run_q    <= run_d;
      start_q  <= start_d;
      ereset_q <= ereset_d;
    end
  end

  // Done delay line, independent of the FSM state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= '0;
    end else begin
      done_q[0] <= done_req;
      for (int i = 1; i < DONE_DELAY; i++) begin
        done_q[i] <= done_q[i-1];
      end
    end
  end

  assign job_running  = run_q;
  assign job_done     = done_q[DONE_DELAY-1];
  assign job_error    = err_q;
  assign job_cack     = 1'b0;
  assign job_yield    = 1'b0;
  assign wed          = wed_q;
  assign engine_start = start_q;
  assign engine_reset = ereset_q;

endmodule

// File: tb/tb_job_control.sv
// tb_job_control: directed checks of job_control
// with default parameters (RESET_CYCLES=4, DONE_DELAY=2).
module tb_job_control;

  logic        clock;
  logic        reset_n;
  logic        job_valid;
  logic [7:0]  job_command;
  logic [63:0] job_address;
  logic        job_running;
  logic        job_done;
  logic [63:0] job_error;
  logic        job_cack;
  logic        job_yield;
  logic [63:0] wed;
  logic        engine_start;
  logic        engine_reset;
  logic        engine_done;
  logic        engine_error;
  logic [63:0] engine_error_code;
  logic        engine_idle;

  int vectors;
  int errs;

  job_control dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .job_valid         (job_valid),
    .job_command       (job_command),
    .job_address       (job_address),
    .job_running       (job_running),
    .job_done          (job_done),
    .job_error         (job_error),
    .job_cack          (job_cack),
    .job_yield         (job_yield),
    .wed               (wed),
    .engine_start      (engine_start),
    .engine_reset      (engine_reset),
    .engine_done       (engine_done),
    .engine_error      (engine_error),
    .engine_error_code (engine_error_code),
    .engine_idle       (engine_idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    job_valid         = 1'b0;
    job_command       = 8'h00;
    job_address       = 64'd0;
    engine_done       = 1'b0;
    engine_error      = 1'b0;
    engine_error_code = 64'd0;
    engine_idle       = 1'b1;
  endtask

  task automatic cmd(input logic [7:0] c,
                     input logic [63:0] a);
    job_valid   = 1'b1;
    job_command = c;
    job_address = a;
  endtask

  task automatic test_reset();
    logic [199:0] all;
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      job_valid         = 1'($urandom);
      job_command       = (i % 2 == 0) ? 8'h90 : 8'h80;
      job_address       = {$urandom, $urandom};
      engine_done       = 1'($urandom);
      engine_error      = 1'($urandom);
      engine_error_code = {$urandom, $urandom};
      engine_idle       = 1'($urandom);
      step();
      all = {job_running, job_done, job_error, job_cack,
             job_yield, wed, engine_start, engine_reset,
             64'd0};
      vectors++;
      if (all !== 200'd0) begin
        errs++;
        $display("FAIL reset_outputs got=%h want=0", all);
      end
    end
    idle_inputs();
    reset_n = 1'b1;
    step();
    cmd(8'h55, 64'hFFFF);
    step();
    job_valid = 1'b0;
    vectors++;
    if ({engine_start, job_running, engine_reset}
        !== 3'b000) begin
      errs++;
      $display("FAIL idle_ignore got=%b want=000",
               {engine_start, job_running, engine_reset});
    end
    vectors++;
    if ({job_cack, job_yield} !== 2'b00) begin
      errs++;
      $display("FAIL cack_yield got=%b want=00",
               {job_cack, job_yield});
    end
  endtask

  task automatic run_job(input logic err,
                         input logic [63:0] code,
                         input string nm);
    cmd(8'h90, 64'h0000_1234_5678_9ABC);
    step();
    job_valid = 1'b0;
    vectors++;
    if ({engine_start, job_running} !== 2'b11) begin
      errs++;
      $display("FAIL %s_start got=%b want=11", nm,
               {engine_start, job_running});
    end
    vectors++;
    if (wed !== 64'h0000_1234_5678_9ABC) begin
      errs++;
      $display("FAIL %s_wed got=%h want=123456789abc",
               nm, wed);
    end
    step();
    vectors++;
    if ({engine_start, job_running} !== 2'b01) begin
      errs++;
      $display("FAIL %s_pulse got=%b want=01", nm,
               {engine_start, job_running});
    end
    cmd(8'h90, 64'h5555);
    step();
    job_valid = 1'b0;
    vectors++;
    if (engine_start !== 1'b0 ||
        wed !== 64'h0000_1234_5678_9ABC) begin
      errs++;
      $display("FAIL %s_restart_ign got=%b/%h want=0/wed",
               nm, engine_start, wed);
    end
    for (int i = 0; i < 6; i++) step();
    engine_done       = 1'b1;
    engine_error      = err;
    engine_error_code = code;
    step();
    engine_done = 1'b0;
    engine_error_code = 64'd0;
    vectors++;
    if ({job_running, job_done} !== 2'b00) begin
      errs++;
      $display("FAIL %s_m got=%b want=00", nm,
               {job_running, job_done});
    end
    step();
    vectors++;
    if (job_done !== 1'b1 ||
        job_error !== (err ? code : 64'd0)) begin
      errs++;
      $display("FAIL %s_done got=%b/%h want=1/%h", nm,
               job_done, job_error, err ? code : 64'd0);
    end
    step();
    vectors++;
    if (job_done !== 1'b0 ||
        job_error !== (err ? code : 64'd0)) begin
      errs++;
      $display("FAIL %s_after got=%b/%h want=0/%h", nm,
               job_done, job_error, err ? code : 64'd0);
    end
  endtask

  task automatic test_normal();
    run_job(1'b0, 64'hDEAD, "normal");
  endtask

  task automatic test_error();
    run_job(1'b1, 64'hDEAD, "error");
  endtask

  task automatic test_reset_seq();
    cmd(8'h80, 64'd0);
    step();
    job_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      vectors++;
      if ({engine_reset, job_done} !== 2'b10) begin
        errs++;
        $display("FAIL rst_hold%0d got=%b want=10", i,
                 {engine_reset, job_done});
      end
    end
    step();
    vectors++;
    if ({engine_reset, job_done} !== 2'b00 ||
        wed !== 64'd0) begin
      errs++;
      $display("FAIL rst_end got=%b/%h want=00/0",
               {engine_reset, job_done}, wed);
    end
    step();
    vectors++;
    if (job_done !== 1'b1 || job_error !== 64'd0) begin
      errs++;
      $display("FAIL rst_done got=%b/%h want=1/0",
               job_done, job_error);
    end
    step();
    engine_idle = 1'b0;
    cmd(8'h80, 64'd0);
    step();
    job_valid = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      vectors++;
      if ({engine_reset, job_done} !== 2'b10) begin
        errs++;
        $display("FAIL busy_hold%0d got=%b want=10", i,
                 {engine_reset, job_done});
      end
    end
    engine_idle = 1'b1;
    step();
    vectors++;
    if ({engine_reset, job_done} !== 2'b00) begin
      errs++;
      $display("FAIL busy_end got=%b want=00",
               {engine_reset, job_done});
    end
    step();
    vectors++;
    if (job_done !== 1'b1) begin
      errs++;
      $display("FAIL busy_done got=%b want=1", job_done);
    end
  endtask

  task automatic test_abort();
    int pulses;
    int at;
    int low_at;
    logic [63:0] perr;
    cmd(8'h90, 64'hABCD);
    step();
    job_valid = 1'b0;
    step();
    step();
    cmd(8'h80, 64'd0);
    engine_done       = 1'b1;
    engine_error      = 1'b1;
    engine_error_code = 64'hBEEF;
    step();
    idle_inputs();
    vectors++;
    if ({engine_reset, job_running} !== 2'b10) begin
      errs++;
      $display("FAIL abort_enter got=%b want=10",
               {engine_reset, job_running});
    end
    pulses = 0;
    at = -1;
    perr = 64'hX;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (job_done === 1'b1) begin
        pulses++;
        if (at < 0) begin
          at = i;
          perr = job_error;
        end
      end
    end
    vectors++;
    if (pulses !== 1 || at !== 5 || perr !== 64'd0) begin
      errs++;
      $display("FAIL abort_done got=%0d@%0d/%h want=1@5/0",
               pulses, at, perr);
    end
    cmd(8'h80, 64'd0);
    step();
    job_valid = 1'b0;
    step();
    cmd(8'h80, 64'd0);
    step();
    job_valid = 1'b0;
    pulses = 0;
    at = -1;
    low_at = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (engine_reset === 1'b0 && low_at < 0) low_at = i;
      if (job_done === 1'b1) begin
        pulses++;
        if (at < 0) at = i;
      end
    end
    vectors++;
    if (low_at !== 4) begin
      errs++;
      $display("FAIL rereset_len got=%0d want=4", low_at);
    end
    vectors++;
    if (pulses !== 1 || at !== 5) begin
      errs++;
      $display("FAIL rereset_done got=%0d@%0d want=1@5",
               pulses, at);
    end
  endtask

  task automatic test_async();
    int pulses;
    cmd(8'h90, 64'h77);
    step();
    job_valid = 1'b0;
    step();
    engine_done = 1'b1;
    step();
    engine_done = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({job_running, job_done, wed, engine_reset}
        !== 67'd0) begin
      errs++;
      $display("FAIL async_clr got=%b/%b/%h want=0",
               job_running, job_done, wed);
    end
    step();
    reset_n = 1'b1;
    cmd(8'h80, 64'd0);
    step();
    job_valid = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    vectors++;
    if (engine_reset !== 1'b0) begin
      errs++;
      $display("FAIL async_rst got=%b want=0",
               engine_reset);
    end
    step();
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (job_done === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0 || engine_reset !== 1'b0) begin
      errs++;
      $display("FAIL async_nodone got=%0d/%b want=0/0",
               pulses, engine_reset);
    end
  endtask

  task automatic test_back_to_back();
    cmd(8'h90, 64'h1111);
    step();
    job_valid = 1'b0;
    step();
    engine_done = 1'b1;
    step();
    engine_done = 1'b0;
    step();
    vectors++;
    if (job_done !== 1'b1) begin
      errs++;
      $display("FAIL b2b_done got=%b want=1", job_done);
    end
    cmd(8'h90, 64'h2222);
    step();
    job_valid = 1'b0;
    vectors++;
    if ({engine_start, job_running, job_done} !== 3'b110 ||
        wed !== 64'h2222) begin
      errs++;
      $display("FAIL b2b_start got=%b/%h want=110/2222",
               {engine_start, job_running, job_done}, wed);
    end
    engine_done = 1'b1;
    step();
    engine_done = 1'b0;
    step();
    step();
  endtask

  initial begin
    vectors = 0;
    errs = 0;
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_normal();
    test_error();
    test_reset_seq();
    test_abort();
    test_async();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
